// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache controller.
// Hits are served combinationally; misses fetch a 128-bit block from instruction memory.
module icache_ctrl #(
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 3
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic [31:0]                    ADDRESS,
    output logic [31:0]                    INSTRUCTION,
    output logic                           BUSYWAIT,
    output logic                           MEM_READ,
    output logic [TAG_BITS+INDEX_BITS-1:0] MEM_ADDRESS,
    input  logic [127:0]                   MEM_READDATA,
    input  logic                           MEM_BUSYWAIT
);

    // state  | meaning
    // IDLE   | serve hits, detect misses and latch the block address
    // MEM_RD | block read outstanding at instruction memory
    // UPDATE | write the returned block into the latched line
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] MEM_RD = 2'd1;
    localparam logic [1:0] UPDATE = 2'd2;

    localparam int LINES = 1 << INDEX_BITS;
    localparam int BA    = TAG_BITS + INDEX_BITS;

    logic [1:0]          state_q, state_d;
    logic [BA-1:0]       blk_q, blk_d;
    logic [LINES-1:0]    valid_q, valid_d;
    logic [TAG_BITS-1:0] tag_mem_q [LINES];
    logic [127:0]        data_q [LINES];

    logic [INDEX_BITS-1:0] addr_index;
    logic [TAG_BITS-1:0]   addr_tag;
    logic [1:0]            addr_offset;
    logic [INDEX_BITS-1:0] fill_index;
    logic [TAG_BITS-1:0]   fill_tag;
    logic                  no_req;
    logic                  hit;
    logic                  fill_en;
    logic [127:0]          line;
    logic [31:0]           word;

    assign addr_offset = ADDRESS[3:2];
    assign addr_index  = ADDRESS[3+INDEX_BITS:4];
    assign addr_tag    = ADDRESS[9:4+INDEX_BITS];
    assign fill_index  = blk_q[INDEX_BITS-1:0];
    assign fill_tag    = blk_q[BA-1:INDEX_BITS];

    // The PC reset value is not a real fetch and must never trigger a fill.
    assign no_req = (ADDRESS == 32'hFFFF_FFFC);
    assign hit    = valid_q[addr_index] && (tag_mem_q[addr_index] == addr_tag);
    assign line   = data_q[addr_index];

    always_comb begin
        word = line[31:0];
        case (addr_offset)
            2'd0: word = line[31:0];
            2'd1: word = line[63:32];
            2'd2: word = line[95:64];
            2'd3: word = line[127:96];
            default: word = line[31:0];
        endcase
    end

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        valid_d = valid_q;
        fill_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (!no_req && !hit) begin
                    blk_d   = {addr_tag, addr_index};
                    state_d = MEM_RD;
                end
            end
            MEM_RD: begin
                if (!MEM_BUSYWAIT) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                valid_d[fill_index] = 1'b1;
                fill_en             = 1'b1;
                state_d             = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            blk_q   <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            valid_q <= valid_d;
        end
    end

    // Line payload needs no reset: it is only observable once its valid bit is set.
    always_ff @(posedge CLK) begin
        if (fill_en) begin
            data_q[fill_index]    <= MEM_READDATA;
            tag_mem_q[fill_index] <= fill_tag;
        end
    end

    assign MEM_READ    = (state_q == MEM_RD);
    assign MEM_ADDRESS = blk_q;
    // Gated by RESET so the stall releases the instant reset asserts, not at the next edge.
    assign BUSYWAIT    = RESET && ((state_q != IDLE) || (!no_req && !hit));
    assign INSTRUCTION = (state_q == IDLE && hit && !no_req) ? word : 32'h0;

endmodule
